// File: rtl/mult_arb_pkg.sv
// Shared types and sizing helpers for the multiplier round-robin arbiter.
package mult_arb_pkg;

  // Operand/result width of the shared sequential multiplier.
  localparam int DW_DEF = 16;

  // Arbiter FSM encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } arb_state_t;

  // Watchdog counter width: enough to hold TIMEOUT-1, never narrower than 1.
  function automatic int wd_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

  // Requester index width: enough to address N requesters, never narrower than 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// scanning upward with wrap-around. Returns one-hot grant and its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gidx
);

  // ptr is always below N, so ptr+k is below 2N and one subtraction wraps it.
  function automatic logic [IW-1:0] wrap_idx(input int unsigned v);
    if (v >= N) begin
      return IW'(v - N);
    end
    return IW'(v);
  endfunction

  logic found;

  // Scan the N positions starting at ptr; the first pending request wins.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_idx(int'(ptr) + k)]) begin
        found = 1'b1;
        gidx  = wrap_idx(int'(ptr) + k);
        gnt[wrap_idx(int'(ptr) + k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one sequential multiplier between N clients.
// Accepts one operand pair at a time, drives the two-cycle A/B load protocol,
// waits for Done under a watchdog and returns the product (or an error) on a
// per-requester valid/ready response channel.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_a,
  input  logic [N*DW-1:0] req_b,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            mult_start,
  output logic [DW-1:0]   mult_in,
  input  logic [DW-1:0]   mult_out,
  input  logic            mult_done
);

  localparam int IW = idx_width(N);
  localparam int WW = wd_width(TIMEOUT);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx_q;
  logic [N-1:0]  gnt_q;
  logic [WW-1:0] wd;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          take;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .gidx (pick_idx)
  );

  assign take = (state == IDLE) && (|req_valid);

  // Control path: FSM, grant/pointer bookkeeping, watchdog and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx_q    <= '0;
      gnt_q     <= '0;
      wd        <= '0;
      req_ready <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            req_ready <= pick_gnt;
            gnt_q     <= pick_gnt;
            gidx_q    <= pick_idx;
            state     <= LOAD_A;
          end
        end
        LOAD_A: begin
          state <= LOAD_B;
        end
        LOAD_B: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Done is only meaningful here; earlier pulses belong to a previous op.
          if (mult_done) begin
            rsp_data <= mult_out;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          // Only the granted requester's ready bit can retire the response.
          if (rsp_ready[gidx_q]) begin
            ptr   <= (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand latch: capture the granted pair as it is accepted; no reset needed
  // since the values are only consumed after a grant.
  always_ff @(posedge clk) begin
    if (take) begin
      a_q <= req_a[int'(pick_idx) * DW +: DW];
      b_q <= req_b[int'(pick_idx) * DW +: DW];
    end
  end

  // Outputs decoded from state and registers only, so no request-side
  // combinational path reaches the multiplier or the response channel.
  always_comb begin
    mult_start = (state == LOAD_A);
    rsp_valid  = (state == RESP) ? gnt_q : '0;
    case (state)
      LOAD_A:       mult_in = a_q;
      LOAD_B, WAIT: mult_in = b_q;
      default:      mult_in = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural sequential-multiplier stub.
module tb_mult_arbiter;

  localparam int N       = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;
  localparam int K       = 3;   // stub Done appears K cycles after B is loaded

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            mult_start;
  logic [DW-1:0]   mult_in;
  logic [DW-1:0]   mult_out;
  logic            mult_done;

  always #5 clk = ~clk;

  mult_arbiter #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .mult_start (mult_start),
    .mult_in    (mult_in),
    .mult_out   (mult_out),
    .mult_done  (mult_done)
  );

  // Multiplier stub: A on start, B the next cycle, Done pulse K cycles later.
  logic          hang;
  logic          stale_en;
  logic [1:0]    ph;
  int            cnt;
  logic [DW-1:0] ma, mb, mout;
  logic          done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph <= 2'd0; cnt <= 0; ma <= '0; mb <= '0; mout <= '0; done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mult_start) begin
        ma <= mult_in;
        ph <= 2'd1;
      end else if (ph == 2'd1) begin
        mb  <= mult_in;
        ph  <= 2'd2;
        cnt <= 1;
      end else if (ph == 2'd2) begin
        if (cnt == K) begin
          ph <= 2'd0;
          if (!hang) begin
            done_q <= 1'b1;
            mout   <= ma * mb;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  assign mult_out  = mout;
  assign mult_done = done_q | (stale_en & mult_start);

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; rsp_ready = '0; hang = 1'b0; stale_en = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  // Wait for the grant pulse, check it, and withdraw the granted request.
  task automatic wait_grant(input int idx, input string tag);
    int c;
    c = 0;
    while (req_ready == '0 && c < 50) begin
      step(); c++;
    end
    chk({tag, "_grant"}, 32'(req_ready), 32'(1 << idx));
    req_valid = req_valid & ~req_ready;
  endtask

  // Wait for a response, compare against the scoreboard head, then retire it.
  task automatic wait_rsp(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (rsp_valid == '0 && lat < 200) begin
      step(); lat++;
    end
    chk({tag, "_sbq"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << e.idx));
      chk({tag, "_rsp_data"},  32'(rsp_data),  32'(e.data));
      chk({tag, "_rsp_err"},   32'(rsp_err),   32'(e.err));
      rsp_ready[e.idx] = 1'b1;
      step();
      rsp_ready = '0;
      chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_rsp_data"},   32'(rsp_data),   32'd0);
    chk({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    chk({tag, "_mult_start"}, 32'(mult_start), 32'd0);
    chk({tag, "_mult_in"},    32'(mult_in),    32'd0);
  endtask

  initial begin
    int lat;
    req_a = '0; req_b = '0;

    // Reset values
    do_reset();
    chk_idle_outputs("reset");

    // Single request from requester 1: 7*3
    set_req(1, 16'd7, 16'd3);
    sbq.push_back('{1, 16'd21, 1'b0});
    wait_grant(1, "t1");
    chk("t1_start_hi", 32'(mult_start), 32'd1);
    chk("t1_in_a",     32'(mult_in),    32'd7);
    step();
    chk("t1_start_lo", 32'(mult_start), 32'd0);
    chk("t1_in_b",     32'(mult_in),    32'd3);
    wait_rsp("t1", lat);
    // Response lands 3+K cycles after the grant; one cycle was already consumed.
    chk("t1_latency", 32'(lat), 32'(3 + K - 1));

    // All four requesters valid: fair rotation from ptr=0
    do_reset();
    set_req(0, 16'd2, 16'd3);
    set_req(1, 16'd4, 16'd5);
    set_req(2, 16'd6, 16'd7);
    set_req(3, 16'd8, 16'd9);
    sbq.push_back('{0, 16'd6,  1'b0});
    sbq.push_back('{1, 16'd20, 1'b0});
    sbq.push_back('{2, 16'd42, 1'b0});
    sbq.push_back('{3, 16'd72, 1'b0});
    for (int i = 0; i < N; i++) begin
      wait_grant(i, $sformatf("rr%0d", i));
      wait_rsp($sformatf("rr%0d", i), lat);
    end

    // Backpressure on requester 0 while requester 2 waits
    set_req(0, 16'd10, 16'd11);
    set_req(2, 16'd3,  16'd4);
    sbq.push_back('{0, 16'd110, 1'b0});
    sbq.push_back('{2, 16'd12,  1'b0});
    wait_grant(0, "bp0");
    lat = 0;
    while (rsp_valid == '0 && lat < 200) begin
      step(); lat++;
    end
    rsp_ready = 4'b0100;   // non-granted ready bit must be ignored
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_hold%0d_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d_data", c),  32'(rsp_data),  32'd110);
      chk($sformatf("bp_hold%0d_grant", c), 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = '0;
    wait_rsp("bp0", lat);
    wait_grant(2, "bp2");
    wait_rsp("bp2", lat);

    // Watchdog timeout, then normal service resumes
    hang = 1'b1;
    set_req(1, 16'd9, 16'd9);
    sbq.push_back('{1, 16'd0, 1'b1});
    wait_grant(1, "to");
    wait_rsp("to", lat);
    // WAIT starts 2 cycles after the grant, runs TIMEOUT cycles, response follows.
    chk("to_latency", 32'(lat), 32'(TIMEOUT + 2));
    hang = 1'b0;
    set_req(2, 16'd6, 16'd7);
    sbq.push_back('{2, 16'd42, 1'b0});
    wait_grant(2, "after_to");
    wait_rsp("after_to", lat);
    chk("after_to_latency", 32'(lat), 32'(3 + K));

    // Stale Done pulse during LOAD_A is ignored
    stale_en = 1'b1;
    set_req(3, 16'd12, 16'd12);
    sbq.push_back('{3, 16'd144, 1'b0});
    wait_grant(3, "stale");
    step();
    stale_en = 1'b0;
    wait_rsp("stale", lat);
    chk("stale_latency", 32'(lat), 32'(3 + K - 1));

    // Move ptr away from 0, then reset in the middle of WAIT
    set_req(1, 16'd11, 16'd3);
    sbq.push_back('{1, 16'd33, 1'b0});
    wait_grant(1, "pre_rst");
    wait_rsp("pre_rst", lat);
    set_req(2, 16'd2, 16'd2);
    wait_grant(2, "abort");
    step(); step(); step();
    rst = 1'b0;
    step();
    chk_idle_outputs("midrst");
    step();
    rst = 1'b1;
    step();
    // ptr must be back at 0: requester 1 wins over 3
    set_req(1, 16'd4, 16'd4);
    set_req(3, 16'd5, 16'd5);
    sbq.push_back('{1, 16'd16, 1'b0});
    sbq.push_back('{3, 16'd25, 1'b0});
    wait_grant(1, "post_rst1");
    wait_rsp("post_rst1", lat);
    wait_grant(3, "post_rst3");
    wait_rsp("post_rst3", lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
